noc_link_recorder: RTL and testbench

Passive per-link NoC packet recorder that sits between the system's link taps (link_in/link_out flit, last, valid, ready per channel) and the NoC trace/logging consumer. It observes completed handshakes, assembles one record per packet (channel, header flit, length, start/end timestamps), and buffers the records. Records leave through a valid/ready stream, so a slow logger never stalls the monitored link. The block never drives the link.

---
 rtl/noc_recorder_pkg.sv | 30 +++
 rtl/noc_link_recorder_fifo.sv | 50 +++++
 rtl/noc_link_recorder.sv | 201 ++++++++++++++++++++
 tb/tb_noc_link_recorder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_recorder_pkg.sv
// Shared types and constants for the NoC link recorder.
// Record layout, channel FSM states and default geometry.
package noc_recorder_pkg;

  localparam int DEF_CHANNELS = 2;
  localparam int DEF_FLIT_W   = 32;
  localparam int DEF_TS_W     = 32;
  localparam int DEF_LEN_W    = 8;
  localparam int DROP_W       = 16;

  function automatic int ch_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_bits(DEF_CHANNELS);

  typedef enum logic {
    CH_IDLE,
    CH_IN_PKT
  } ch_state_e;

  typedef struct packed {
    logic [CH_W-1:0]       channel;
    logic [DEF_FLIT_W-1:0] header;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_TS_W-1:0]   ts_start;
    logic [DEF_TS_W-1:0]   ts_end;
  } noc_rec_t;

endpackage

// File: rtl/noc_link_recorder_fifo.sv
// First-word-fall-through record FIFO.
// Head entry reads as zero while empty.
module noc_link_recorder_fifo
  import noc_recorder_pkg::*;
#(
  parameter type rec_t = noc_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t wdata,
  output logic full,
  input  logic pop,
  output rec_t rdata,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since reads gate on empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_link_recorder.sv
// Passive NoC link recorder: per-channel packet assembly,
// one-entry staging slots, round-robin drain into a record FIFO.
module noc_link_recorder
  import noc_recorder_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int FLIT_WIDTH = DEF_FLIT_W,
  parameter int TS_WIDTH   = DEF_TS_W,
  parameter int LEN_WIDTH  = DEF_LEN_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] flit,
  input  logic [CHANNELS-1:0]            last,
  input  logic [CHANNELS-1:0]            valid,
  input  logic [CHANNELS-1:0]            ready,
  output logic                           rec_valid,
  input  logic                           rec_ready,
  output logic [ch_bits(CHANNELS)-1:0]   rec_channel,
  output logic [FLIT_WIDTH-1:0]          rec_header,
  output logic [LEN_WIDTH-1:0]           rec_len,
  output logic [TS_WIDTH-1:0]            rec_ts_start,
  output logic [TS_WIDTH-1:0]            rec_ts_end,
  output logic [DROP_W-1:0]              drop_cnt,
  output logic                           busy
);

  localparam int CW = ch_bits(CHANNELS);

  typedef struct packed {
    logic [CW-1:0]         channel;
    logic [FLIT_WIDTH-1:0] header;
    logic [LEN_WIDTH-1:0]  len;
    logic [TS_WIDTH-1:0]   ts_start;
    logic [TS_WIDTH-1:0]   ts_end;
  } slot_t;

  ch_state_e             state_q [CHANNELS];
  ch_state_e             state_d [CHANNELS];
  logic [FLIT_WIDTH-1:0] hdr_q   [CHANNELS];
  logic [TS_WIDTH-1:0]   tss_q   [CHANNELS];
  logic [LEN_WIDTH-1:0]  len_q   [CHANNELS];
  slot_t                 cur_rec [CHANNELS];
  slot_t                 slot_q  [CHANNELS];
  logic [CHANNELS-1:0]   slot_full_q;
  logic [CHANNELS-1:0]   xfer;
  logic [CHANNELS-1:0]   done;
  logic [CHANNELS-1:0]   drain;
  logic [CHANNELS-1:0]   drop;
  logic [CHANNELS-1:0]   in_pkt;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [CW-1:0]         ptr_q;
  logic [CW-1:0]         gnt;
  logic                  gnt_vld;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  slot_t                 head;
  logic [31:0]           drop_sum;

  assign xfer = valid & ready;

  // Free-running timestamp, zero in the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 1'b1;
  end

  // Per-channel packet FSM: builds the record as of this transfer.
  always_comb begin
    done   = '0;
    in_pkt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      in_pkt[c]  = (state_q[c] == CH_IN_PKT);
      cur_rec[c] = '0;
      cur_rec[c].channel = CW'(c);
      cur_rec[c].ts_end  = ts_q;
      unique case (state_q[c])
        CH_IDLE: begin
          cur_rec[c].header   = flit[c*FLIT_WIDTH +: FLIT_WIDTH];
          cur_rec[c].len      = LEN_WIDTH'(1);
          cur_rec[c].ts_start = ts_q;
          if (xfer[c]) begin
            if (last[c]) done[c] = 1'b1;
            else         state_d[c] = CH_IN_PKT;
          end
        end
        CH_IN_PKT: begin
          cur_rec[c].header   = hdr_q[c];
          cur_rec[c].len      = (len_q[c] == '1) ?
                                len_q[c] : len_q[c] + 1'b1;
          cur_rec[c].ts_start = tss_q[c];
          if (xfer[c] && last[c]) begin
            done[c]    = 1'b1;
            state_d[c] = CH_IDLE;
          end
        end
      endcase
    end
  end

  // FSM state and in-flight packet accumulators.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!rst) begin
        state_q[c] <= CH_IDLE;
        hdr_q[c]   <= '0;
        tss_q[c]   <= '0;
        len_q[c]   <= '0;
      end else begin
        state_q[c] <= state_d[c];
        if (xfer[c]) begin
          hdr_q[c] <= cur_rec[c].header;
          tss_q[c] <= cur_rec[c].ts_start;
          len_q[c] <= cur_rec[c].len;
        end
      end
    end
  end

  // Round-robin pick of the first full slot at or after the pointer.
  always_comb begin
    gnt     = ptr_q;
    gnt_vld = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (slot_full_q[(int'(ptr_q) + i) % CHANNELS]) begin
        gnt     = CW'((int'(ptr_q) + i) % CHANNELS);
        gnt_vld = 1'b1;
      end
    end
  end

  assign pop     = rec_valid & rec_ready;
  assign push_ok = gnt_vld & (~fifo_full | pop);

  // Drain and drop decisions per staging slot.
  always_comb begin
    drain = '0;
    drop  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      drain[c] = push_ok && (int'(gnt) == c);
      drop[c]  = done[c] & slot_full_q[c] & ~drain[c];
    end
  end

  // Staging slots: a drained slot may refill in the same cycle.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!rst) begin
        slot_q[c]      <= '0;
        slot_full_q[c] <= 1'b0;
      end else if (done[c] && (!slot_full_q[c] || drain[c])) begin
        slot_q[c]      <= cur_rec[c];
        slot_full_q[c] <= 1'b1;
      end else if (drain[c]) begin
        slot_full_q[c] <= 1'b0;
      end
    end
  end

  assign drop_sum = 32'(drop_cnt) + 32'($countones(drop));

  // Arbiter pointer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok)
        ptr_q <= (int'(gnt) == CHANNELS - 1) ? '0 : gnt + 1'b1;
      drop_cnt <= (drop_sum > 32'((1 << DROP_W) - 1)) ?
                  {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  noc_link_recorder_fifo #(
    .rec_t (slot_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (slot_q[gnt]),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty)
  );

  assign rec_valid    = ~fifo_empty;
  assign rec_channel  = head.channel;
  assign rec_header   = head.header;
  assign rec_len      = head.len;
  assign rec_ts_start = head.ts_start;
  assign rec_ts_end   = head.ts_end;
  assign busy         = (|in_pkt) | (|slot_full_q) | ~fifo_empty;

endmodule

// File: tb/tb_noc_link_recorder.sv
// Bench for noc_link_recorder: directed scenarios plus a randomized
// phase checked against a packet-level reference model.
module tb_noc_link_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] flit;
  logic [1:0]  last, valid, ready;
  logic        rec_ready;

  logic        a_valid, a_busy;
  logic [0:0]  a_ch;
  logic [31:0] a_hdr, a_tss, a_tse;
  logic [7:0]  a_len;
  logic [15:0] a_drop;

  logic        b_valid, b_busy;
  logic [0:0]  b_ch;
  logic [31:0] b_hdr;
  logic [3:0]  b_tss, b_tse;
  logic [7:0]  b_len;
  logic [15:0] b_drop;

  always #5 clk = ~clk;

  noc_link_recorder u_a (
    .clk(clk), .rst(rst), .flit(flit), .last(last),
    .valid(valid), .ready(ready), .rec_valid(a_valid),
    .rec_ready(rec_ready), .rec_channel(a_ch),
    .rec_header(a_hdr), .rec_len(a_len),
    .rec_ts_start(a_tss), .rec_ts_end(a_tse),
    .drop_cnt(a_drop), .busy(a_busy)
  );

  noc_link_recorder #(.TS_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .flit(flit), .last(last),
    .valid(valid), .ready(ready), .rec_valid(b_valid),
    .rec_ready(rec_ready), .rec_channel(b_ch),
    .rec_header(b_hdr), .rec_len(b_len),
    .rec_ts_start(b_tss), .rec_ts_end(b_tse),
    .drop_cnt(b_drop), .busy(b_busy)
  );

  typedef struct {
    int          ch;
    logic [31:0] hdr;
    logic [7:0]  len;
    logic [31:0] tss;
    logic [31:0] tse;
    logic [3:0]  btss;
    logic [3:0]  btse;
    logic [31:0] at;
  } rec_s;

  rec_s        got_q[$];
  rec_s        exp_q[2][$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] now;

  always @(negedge clk) begin
    if (a_valid === 1'b1 && rec_ready === 1'b1)
      got_q.push_back('{int'(a_ch), a_hdr, a_len, a_tss, a_tse,
                        b_tss, b_tse, now});
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle_in();
    valid = '0; ready = '0; last = '0; flit = '0;
  endtask

  task automatic wait_until(input logic [31:0] t);
    while (now < t) tick();
  endtask

  task automatic send(input int c, input logic [31:0] f, input logic l);
    idle_in();
    valid[c] = 1'b1; ready[c] = 1'b1; last[c] = l;
    flit[c*32 +: 32] = f;
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    now = 0;
  endtask

  // Packet-level reference state for the random phase.
  logic        m_in [2];
  logic [31:0] m_hdr [2];
  logic [31:0] m_ts0 [2];
  int          m_n [2];

  task automatic model_xfer(input int c, input logic [31:0] f,
                            input logic l);
    rec_s r;
    if (!m_in[c]) begin
      m_in[c] = 1'b1; m_hdr[c] = f; m_ts0[c] = now; m_n[c] = 0;
    end
    m_n[c]++;
    if (l) begin
      r = '{c, m_hdr[c], (m_n[c] > 255) ? 8'd255 : 8'(m_n[c]),
            m_ts0[c], now, 4'd0, 4'd0, 32'd0};
      exp_q[c].push_back(r);
      m_in[c] = 1'b0;
    end
  endtask

  initial begin
    rec_s        r;
    logic [31:0] f;
    logic [31:0] seq;
    logic [15:0] drop0;
    int          skipped;
    logic        v, rd, l;

    now = 0;
    rec_ready = 1'b0;
    do_reset();

    chk("rst_valid", a_valid, 0);
    chk("rst_channel", a_ch, 0);
    chk("rst_header", a_hdr, 0);
    chk("rst_len", a_len, 0);
    chk("rst_ts_start", a_tss, 0);
    chk("rst_ts_end", a_tse, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_busy", a_busy, 0);

    // Single-flit packet at ts 10.
    rec_ready = 1'b1;
    wait_until(10);
    send(0, 32'hA5A5_0001, 1'b1);
    chk("t1_valid_t11", a_valid, 0);
    chk("t1_busy_t11", a_busy, 1);
    tick();
    chk("t1_valid_t12", a_valid, 1);
    repeat (4) tick();
    chk("t1_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      r = got_q.pop_front();
      chk("t1_ch", r.ch, 0);
      chk("t1_hdr", r.hdr, 32'hA5A5_0001);
      chk("t1_len", r.len, 1);
      chk("t1_tss", r.tss, 10);
      chk("t1_tse", r.tse, 10);
    end
    got_q.delete();

    // Backpressured three-flit packet on ch1.
    wait_until(20);
    send(1, 32'h1111_0020, 1'b0);
    send(1, 32'h1111_0021, 1'b0);
    repeat (3) begin
      valid[1] = 1'b1; ready[1] = 1'b0;
      flit[63:32] = 32'hDEAD_BEEF; last[1] = 1'b1;
      tick();
    end
    send(1, 32'h1111_0025, 1'b1);
    repeat (5) tick();
    chk("t2_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      r = got_q.pop_front();
      chk("t2_ch", r.ch, 1);
      chk("t2_hdr", r.hdr, 32'h1111_0020);
      chk("t2_len", r.len, 3);
      chk("t2_tss", r.tss, 20);
      chk("t2_tse", r.tse, 25);
    end
    got_q.delete();

    // Same-cycle completion on both channels at ts 40.
    wait_until(40);
    idle_in();
    valid = 2'b11; ready = 2'b11; last = 2'b11;
    flit = {32'h2222_0040, 32'h3333_0040};
    tick();
    idle_in();
    repeat (6) tick();
    chk("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t3_first_ch", got_q[0].ch, 0);
      chk("t3_first_hdr", got_q[0].hdr, 32'h3333_0040);
      chk("t3_first_at", got_q[0].at, 42);
      chk("t3_second_ch", got_q[1].ch, 1);
      chk("t3_second_at", got_q[1].at, 43);
      chk("t3_second_tss", got_q[1].tss, 40);
    end
    chk("t3_drop", a_drop, 0);
    got_q.delete();

    // Overflow with the consumer stalled.
    rec_ready = 1'b0;
    for (int k = 1; k <= 11; k++) send(0, 32'hB000_0000 | k, 1'b1);
    repeat (2) tick();
    chk("t4_drop", a_drop, 2);
    chk("t4_busy", a_busy, 1);
    chk("t4_valid", a_valid, 1);
    rec_ready = 1'b1;
    repeat (15) tick();
    chk("t4_count", got_q.size(), 9);
    for (int k = 0; k < 9 && k < got_q.size(); k++)
      chk("t4_order", got_q[k].hdr, 32'hB000_0001 + k);
    chk("t4_busy_end", a_busy, 0);
    got_q.delete();

    // Reset in the middle of a packet.
    send(0, 32'hC000_0001, 1'b0);
    chk("t5_busy_mid", a_busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    now = 0;
    chk("t5_drop_rst", a_drop, 0);
    chk("t5_busy_rst", a_busy, 0);
    wait_until(3);
    send(0, 32'hC000_0002, 1'b1);
    repeat (6) tick();
    chk("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      r = got_q.pop_front();
      chk("t5_hdr", r.hdr, 32'hC000_0002);
      chk("t5_len", r.len, 1);
      chk("t5_tss", r.tss, 3);
    end
    chk("t5_drop", a_drop, 0);
    got_q.delete();

    // 300-flit packet: length saturation and 4-bit timestamp wrap.
    wait_until(30);
    send(1, 32'hD000_0000, 1'b0);
    for (int k = 1; k < 300; k++) begin
      send(1, 32'hD000_0000 + k, (k == 299));
      if (k == 150) chk("t6_busy_mid", a_busy, 1);
    end
    repeat (6) tick();
    chk("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      r = got_q.pop_front();
      chk("t6_hdr", r.hdr, 32'hD000_0000);
      chk("t6_len", r.len, 255);
      chk("t6_tss", r.tss, 30);
      chk("t6_tse", r.tse, 329);
      chk("t6_b_tss", r.btss, 14);
      chk("t6_b_tse", r.btse, 9);
    end
    got_q.delete();

    // Randomized traffic against the packet-level model.
    drop0 = a_drop;
    seq = 0;
    for (int c = 0; c < 2; c++) begin
      m_in[c] = 1'b0; m_n[c] = 0; exp_q[c].delete();
    end
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      for (int c = 0; c < 2; c++) begin
        v  = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) != 0);
        l  = ($urandom_range(0, 5) == 0);
        f  = {8'($urandom), 23'(seq), 1'(c)};
        valid[c] = v; ready[c] = rd; last[c] = l;
        flit[c*32 +: 32] = f;
        if (v && rd) model_xfer(c, f, l);
      end
      rec_ready = ($urandom_range(0, 3) != 0);
      seq++;
      tick();
    end
    idle_in();
    for (int c = 0; c < 2; c++) begin
      f = {8'hEE, 23'(seq), 1'(c)};
      valid[c] = 1'b1; ready[c] = 1'b1; last[c] = 1'b1;
      flit[c*32 +: 32] = f;
      model_xfer(c, f, 1'b1);
    end
    tick();
    idle_in();
    rec_ready = 1'b1;
    repeat (20) tick();

    skipped = 0;
    while (got_q.size() > 0) begin
      r = got_q.pop_front();
      if (r.ch < 0 || r.ch > 1) begin
        chk("rnd_channel_range", r.ch, 0);
        continue;
      end
      while (exp_q[r.ch].size() > 0 && exp_q[r.ch][0].hdr != r.hdr) begin
        void'(exp_q[r.ch].pop_front());
        skipped++;
      end
      if (exp_q[r.ch].size() == 0) begin
        chk("rnd_unmatched_hdr", r.hdr, 0);
      end else begin
        chk("rnd_len", r.len, exp_q[r.ch][0].len);
        chk("rnd_tss", r.tss, exp_q[r.ch][0].tss);
        chk("rnd_tse", r.tse, exp_q[r.ch][0].tse);
        chk("rnd_b_tse", r.btse, exp_q[r.ch][0].tse[3:0]);
        void'(exp_q[r.ch].pop_front());
      end
    end
    skipped += exp_q[0].size() + exp_q[1].size();
    chk("rnd_drops", a_drop - drop0, skipped);
    chk("rnd_busy_end", a_busy, 0);
    chk("rnd_valid_end", a_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
